// File: rtl/ffa_port_arbiter.sv
// Purpose: shares one flip-flop array port between requesters A and B (round-robin), after a post-reset init sweep.
// Latency: commands drive the array in their grant cycle; read data returns to the issuing port one cycle later.
// Backpressure: x_ready is the combinational grant; responses cannot be stalled and must be sunk by the requester.
module ffa_port_arbiter #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 3,
    parameter int                DATA_N   = 8,
    parameter bit                INIT_EN  = 1'b1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rsp_valid,
    output logic [DATA_W-1:0] a_rsp_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_wr,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] b_rsp_data,
    output logic [DATA_W-1:0] arr_din,
    output logic [ADDR_W-1:0] arr_addr,
    output logic              arr_wr,
    output logic              arr_rd,
    input  logic [DATA_W-1:0] arr_dout,
    input  logic              arr_error,
    output logic              init_done,
    output logic              err
);

    typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

    // One extra bit so DATA_N == 2^ADDR_W is representable for the range check.
    localparam logic [ADDR_W:0]   N_LIM   = (ADDR_W + 1)'(DATA_N);
    localparam logic [ADDR_W-1:0] IC_LAST = ADDR_W'(DATA_N - 1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ic;
    logic                last_b;       // 1: B was granted most recently
    logic                rsp_pend;
    logic                rsp_owner_b;
    logic                rsp_oor;      // pending read hit an out-of-range address
    logic                err_q;

    logic                run;
    logic                gnt_a;
    logic                gnt_b;
    logic                gnt;
    logic                g_wr;
    logic                g_oor;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;

    // Grant selection: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        run     = (state == S_RUN);
        gnt_a   = run & a_valid & (~b_valid | last_b);
        gnt_b   = run & b_valid & (~a_valid | ~last_b);
        gnt     = gnt_a | gnt_b;
        g_wr    = gnt_b ? b_wr    : a_wr;
        g_addr  = gnt_b ? b_addr  : a_addr;
        g_wdata = gnt_b ? b_wdata : a_wdata;
        g_oor   = gnt & ({1'b0, g_addr} >= N_LIM);
    end

    // State register; reset either starts the sweep or goes straight to service.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= INIT_EN ? S_INIT : S_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: leave INIT after the write to the last entry; RUN is terminal.
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  if (ic == IC_LAST) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = state;
        endcase
    end

    // Sweep counter, round-robin pointer, response tracking and sticky error.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ic          <= '0;
            last_b      <= 1'b1;
            rsp_pend    <= 1'b0;
            rsp_owner_b <= 1'b0;
            rsp_oor     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if (state == S_INIT) begin
                ic <= (ic == IC_LAST) ? '0 : ic + 1'b1;
            end
            if (gnt) begin
                last_b <= gnt_b;
            end
            rsp_pend    <= gnt & ~g_wr;
            rsp_owner_b <= gnt_b;
            rsp_oor     <= g_oor;
            if (g_oor || arr_error) begin
                err_q <= 1'b1;
            end
        end
    end

    // Outputs: everything is forced to its reset value while resetn is low, so a
    // pending response or an in-flight sweep write never leaks through the reset cycle.
    always_comb begin
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        arr_wr      = 1'b0;
        arr_rd      = 1'b0;
        arr_addr    = '0;
        arr_din     = '0;
        a_rsp_valid = 1'b0;
        b_rsp_valid = 1'b0;
        a_rsp_data  = '0;
        b_rsp_data  = '0;
        err         = 1'b0;
        init_done   = ~INIT_EN;
        if (resetn) begin
            case (state)
                S_INIT: begin
                    arr_wr   = 1'b1;
                    arr_addr = ic;
                    arr_din  = INIT_VAL;
                end
                S_RUN: begin
                    a_ready = gnt_a;
                    b_ready = gnt_b;
                    if (gnt) begin
                        arr_addr = g_addr;
                        arr_din  = g_wdata;
                        arr_wr   = g_wr & ~g_oor;
                        arr_rd   = ~g_wr & ~g_oor;
                    end
                end
                default: ;
            endcase
            a_rsp_valid = rsp_pend & ~rsp_owner_b;
            b_rsp_valid = rsp_pend & rsp_owner_b;
            // Out-of-range reads never strobed the array, so its dout is stale: return 0.
            if (a_rsp_valid && !rsp_oor) a_rsp_data = arr_dout;
            if (b_rsp_valid && !rsp_oor) b_rsp_data = arr_dout;
            init_done = run;
            err       = err_q;
        end
    end

endmodule
